// File: rtl/mid_bus_arbiter.sv
// mid_bus_arbiter: round-robin arbiter that shares the 8-bit mid bus between
// the datapath source units and holds the winner in one output register
// (valid/ready toward the output stage). A winner may ask to lock the bus
// for a bounded number of consecutive captures.
module mid_bus_arbiter #(
   parameter int WIDTH    = 8,
   parameter int N_REQ    = 4,
   parameter int MAX_LOCK = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       lock,
   input  logic [N_REQ*WIDTH-1:0] data_in,
   output logic [N_REQ-1:0]       gnt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   locked,
   output logic [15:0]            xfer_count
);

   localparam int IDXW = $clog2(N_REQ);

   typedef enum logic {
      UNLOCKED,
      LOCKED
   } lock_state_t;

   lock_state_t      state_q, state_d;
   logic [IDXW-1:0]  ptr_q, ptr_d;
   logic [IDXW-1:0]  owner_q, owner_d;
   logic [3:0]       lock_cnt_q, lock_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [15:0]      xfer_count_q, xfer_count_d;

   logic             cap_en;
   logic [N_REQ-1:0] owner_mask;
   logic [N_REQ-1:0] eligible;
   logic             found;
   logic [IDXW-1:0]  winner;
   logic             capture;
   int               idx;

   assign cap_en     = !out_valid_q || out_ready;
   assign owner_mask = N_REQ'(1) << owner_q;
   assign eligible   = (state_q == LOCKED) ? (req & owner_mask) : req;
   assign capture    = found && cap_en && !reset;

   // Round-robin search starting just after the last winner; first eligible index wins
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = IDXW'(idx);
         end
      end
   end

   // One-hot accept toward the winning source, only when its data is really taken
   always_comb begin
      gnt = '0;
      if (capture) begin
         gnt[winner] = 1'b1;
      end
   end

   // Next-state for output register, pointer, transfer counter and lock tracking
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      lock_cnt_d   = lock_cnt_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      xfer_count_d = xfer_count_q;

      if (out_valid_q && out_ready) begin
         xfer_count_d = xfer_count_q + 16'd1;
      end

      if (capture) begin
         out_data_d  = data_in[int'(winner)*WIDTH +: WIDTH];
         out_valid_d = 1'b1;
         ptr_d       = winner;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // An owner that stops requesting abandons the lock; nothing is captured then
      if (state_q == LOCKED && !req[owner_q]) begin
         state_d    = UNLOCKED;
         lock_cnt_d = '0;
      end else if (capture) begin
         if (state_q == UNLOCKED) begin
            if (lock[winner] && (MAX_LOCK > 1)) begin
               state_d    = LOCKED;
               owner_d    = winner;
               lock_cnt_d = 4'd1;
            end
         end else begin
            if (lock[owner_q] && ((int'(lock_cnt_q) + 1) < MAX_LOCK)) begin
               lock_cnt_d = lock_cnt_q + 4'd1;
            end else begin
               state_d    = UNLOCKED;
               lock_cnt_d = '0;
            end
         end
      end
   end

   // State registers; ptr resets to the last index so requester 0 goes first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= UNLOCKED;
         ptr_q        <= IDXW'(N_REQ - 1);
         owner_q      <= '0;
         lock_cnt_q   <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         xfer_count_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         lock_cnt_q   <= lock_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign locked     = (state_q == LOCKED);
   assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_mid_bus_arbiter.sv
// tb_mid_bus_arbiter: directed bench for mid_bus_arbiter with the default
// parameters (WIDTH=8, N_REQ=4, MAX_LOCK=4) and hand-computed expectations.
module tb_mid_bus_arbiter;

   localparam int WIDTH    = 8;
   localparam int N_REQ    = 4;
   localparam int MAX_LOCK = 4;

   logic                   clk;
   logic                   reset;
   logic [N_REQ-1:0]       req;
   logic [N_REQ-1:0]       lock;
   logic [N_REQ*WIDTH-1:0] data_in;
   logic [N_REQ-1:0]       gnt;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   locked;
   logic [15:0]            xfer_count;

   int check_count = 0;
   int error_count = 0;

   logic             prev_valid = 1'b0;
   logic             prev_ready = 1'b0;
   logic             prev_reset = 1'b1;
   logic [WIDTH-1:0] prev_data  = '0;

   mid_bus_arbiter #(
      .WIDTH    (WIDTH),
      .N_REQ    (N_REQ),
      .MAX_LOCK (MAX_LOCK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .lock       (lock),
      .data_in    (data_in),
      .gnt        (gnt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .locked     (locked),
      .xfer_count (xfer_count)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then let the combinational accept settle
   task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] l, input logic rdy);
      req       = r;
      lock      = l;
      out_ready = rdy;
      #1;
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Synchronous-looking reset pulse covering one rising edge
   task automatic doReset();
      reset = 1'b1;
      req   = '0;
      lock  = '0;
      step();
      reset = 1'b0;
   endtask

   // Protocol watch on the falling edge: accept one-hot, no accept in reset, data held under backpressure
   always @(negedge clk) begin
      if (reset) begin
         checkOutput("gnt_in_reset", {28'd0, gnt}, 32'd0);
      end
      checkOutput("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (!reset && !prev_reset && prev_valid && !prev_ready) begin
         checkOutput("data_stable", {24'd0, out_data}, {24'd0, prev_data});
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_reset = reset;
      prev_data  = out_data;
   end

   logic [3:0] exp_gnt_rr [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] exp_data_rr [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
   logic [3:0] exp_gnt_lk [6]  = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
   logic       exp_lkd_lk [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      reset     = 1'b1;
      req       = 4'hF;
      lock      = '0;
      out_ready = 1'b1;
      data_in   = {8'h44, 8'h33, 8'h22, 8'h11};

      // Reset state, with requests present to show no accept is given
      step();
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_data", {24'd0, out_data}, 32'd0);
      checkOutput("rst_locked", {31'd0, locked}, 32'd0);
      checkOutput("rst_xfer", {16'd0, xfer_count}, 32'd0);
      checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
      reset = 1'b0;

      // Plain round robin, full throughput
      $display("[TB] round robin");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'hF, 4'h0, 1'b1);
         checkOutput("rr_gnt", {28'd0, gnt}, {28'd0, exp_gnt_rr[i]});
         if (i > 0) checkOutput("rr_data", {24'd0, out_data}, {24'd0, exp_data_rr[i-1]});
         step();
      end
      checkOutput("rr_data_last", {24'd0, out_data}, 32'h11);
      checkOutput("rr_xfer4", {16'd0, xfer_count}, 32'd4);
      applyStimulus(4'h0, 4'h0, 1'b1);
      checkOutput("drain_gnt", {28'd0, gnt}, 32'd0);
      step();
      checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("drain_data_hold", {24'd0, out_data}, 32'h11);
      checkOutput("rr_xfer5", {16'd0, xfer_count}, 32'd5);

      // Backpressure after the first capture
      $display("[TB] backpressure");
      doReset();
      applyStimulus(4'hF, 4'h0, 1'b1);
      checkOutput("bp_gnt0", {28'd0, gnt}, 32'b0001);
      step();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'hF, 4'h0, 1'b0);
         checkOutput("bp_gnt_stall", {28'd0, gnt}, 32'd0);
         checkOutput("bp_data_stall", {24'd0, out_data}, 32'h11);
         step();
      end
      applyStimulus(4'hF, 4'h0, 1'b1);
      checkOutput("bp_gnt1", {28'd0, gnt}, 32'b0010);
      step();
      checkOutput("bp_data1", {24'd0, out_data}, 32'h22);
      checkOutput("bp_xfer", {16'd0, xfer_count}, 32'd1);

      // Lock held to the MAX_LOCK limit, then forced release to the next requester
      $display("[TB] lock limit");
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'hF, 4'b0010, 1'b1);
         checkOutput("lk_gnt", {28'd0, gnt}, {28'd0, exp_gnt_lk[i]});
         checkOutput("lk_locked", {31'd0, locked}, {31'd0, exp_lkd_lk[i]});
         step();
      end
      checkOutput("lk_data_after", {24'd0, out_data}, 32'h33);

      // Lock dropped by the owner on its third capture
      $display("[TB] lock release");
      doReset();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      checkOutput("rel_gnt0", {28'd0, gnt}, 32'b0001);
      step();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      checkOutput("rel_gnt1a", {28'd0, gnt}, 32'b0010);
      step();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      checkOutput("rel_gnt1b", {28'd0, gnt}, 32'b0010);
      checkOutput("rel_locked_b", {31'd0, locked}, 32'd1);
      step();
      applyStimulus(4'hF, 4'b0000, 1'b1);
      checkOutput("rel_gnt1c", {28'd0, gnt}, 32'b0010);
      checkOutput("rel_locked_c", {31'd0, locked}, 32'd1);
      step();
      applyStimulus(4'hF, 4'b0000, 1'b1);
      checkOutput("rel_gnt2", {28'd0, gnt}, 32'b0100);
      checkOutput("rel_locked_off", {31'd0, locked}, 32'd0);
      step();

      // Owner abandons the lock by dropping its request
      $display("[TB] lock abandon");
      doReset();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      step();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      checkOutput("ab_gnt1", {28'd0, gnt}, 32'b0010);
      step();
      applyStimulus(4'b1101, 4'b0010, 1'b1);
      checkOutput("ab_locked", {31'd0, locked}, 32'd1);
      checkOutput("ab_gnt_none", {28'd0, gnt}, 32'd0);
      step();
      applyStimulus(4'b1101, 4'b0010, 1'b1);
      checkOutput("ab_unlocked", {31'd0, locked}, 32'd0);
      checkOutput("ab_valid_drained", {31'd0, out_valid}, 32'd0);
      checkOutput("ab_gnt2", {28'd0, gnt}, 32'b0100);
      step();

      // Transfer counter wrap across 65537 handshakes
      $display("[TB] counter wrap");
      doReset();
      applyStimulus(4'hF, 4'h0, 1'b1);
      step();
      repeat (65535) step();
      checkOutput("wrap_ffff", {16'd0, xfer_count}, 32'hFFFF);
      step();
      checkOutput("wrap_0000", {16'd0, xfer_count}, 32'h0000);
      step();
      checkOutput("wrap_0001", {16'd0, xfer_count}, 32'h0001);

      // Asynchronous reset in the middle of a locked, valid cycle
      $display("[TB] async reset");
      doReset();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      step();
      applyStimulus(4'hF, 4'b0010, 1'b1);
      step();
      checkOutput("ar_pre_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("ar_pre_locked", {31'd0, locked}, 32'd1);
      checkOutput("ar_pre_xfer", {16'd0, xfer_count}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("ar_locked", {31'd0, locked}, 32'd0);
      checkOutput("ar_xfer", {16'd0, xfer_count}, 32'd0);
      checkOutput("ar_data", {24'd0, out_data}, 32'd0);
      checkOutput("ar_gnt", {28'd0, gnt}, 32'd0);
      step();
      checkOutput("ar_xfer_hold", {16'd0, xfer_count}, 32'd0);
      reset = 1'b0;
      applyStimulus(4'hF, 4'h0, 1'b1);
      checkOutput("ar_first_gnt", {28'd0, gnt}, 32'b0001);
      step();
      checkOutput("ar_first_data", {24'd0, out_data}, 32'h11);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
